text_console_writer: RTL and testbench
======================================

// Module: text_console_writer
// PURPOSE
// Producer side of the text-mode display buffer: accepts a character stream (valid/ready) from the CPU
// and writes 32-bit cell words into the text RAM that the pixel painter scans. Maintains a cursor,
// interprets control codes (LF, CR, BS, FF) and scrolls the screen up one row when the cursor leaves the last row.
// Cell word format: {8'h00, color[15:0], char[7:0]}; cell n (row*COLS+col) is stored at word CELL_BASE+n.
// PARAMETERS
// COLS       80      characters per row
// ROWS       27      rows; highest written address CELL_BASE+ROWS*COLS-1 = 2160
// CELL_BASE  1       word address of cell 0
// FILL_COLOR 16'hFFFF  color field written into blank cells (char 8'h20)
// PORTS
// clk         in   1   system clock
// rst         in   1   asynchronous reset, active-high
// in_valid    in   1   character/control byte present
// in_ready    out  1   writer can accept; transfer when in_valid & in_ready
// in_char     in   8   character code or control code
// in_color    in   16  color for printable characters
// mem_we      out  1   text RAM write strobe
// mem_re      out  1   text RAM read strobe (scroll only)
// mem_addr    out  12  text RAM word address
// mem_wdata   out  32  text RAM write data
// mem_rdata   in   32  text RAM read data, valid the cycle after mem_re
// cursor_col  out  7   current column 0..COLS-1
// cursor_row  out  5   current row 0..ROWS-1
// busy        out  1   high in SCROLL/CLEAR states
// BEHAVIOUR
// - Reset: state IDLE, cursor (0,0), in_ready=1, mem_we=mem_re=0, mem_addr=0, mem_wdata=0, busy=0. No clear on reset.
// - States: IDLE, PUT, SCROLL, CLEAR. in_ready = (state==IDLE). All outputs registered.
// - IDLE accept, printable (8'h20..8'h7E, and any code not listed below): -> PUT; next cycle mem_we=1,
//   addr=CELL_BASE+row*COLS+col, wdata={8'h00,in_color,in_char}; col+1; at col==COLS-1 col->0, row+1. Back to IDLE.
// - 8'h0A LF: col->0, row+1. 8'h0D CR: col->0. No memory access; stay IDLE (in_ready stays 1).
// - 8'h08 BS: if col>0 col-1 and write blank cell {8'h00,FILL_COLOR,8'h20} at new position via PUT; col==0: no-op.
// - 8'h0C FF: -> CLEAR: ROWS*COLS consecutive writes of blank cells from CELL_BASE, one per cycle; cursor (0,0).
// - Row advance from ROWS-1 (LF or wrap): row stays ROWS-1, -> SCROLL.
// - SCROLL: pipelined copy; cycle k issues mem_re at cell COLS+k (k=0..(ROWS-1)*COLS-1), cycle k+1 writes
//   mem_rdata to cell k. Read and write may both be active in one cycle. Copy takes (ROWS-1)*COLS+1 cycles,
//   then COLS blank writes to last row, then IDLE. Total (ROWS)*COLS+1 cycles; busy high throughout.
// - Cursor/address arithmetic: row*COLS computed with 12-bit result; addresses never exceed CELL_BASE+ROWS*COLS-1.
// - in_valid while not ready: held by source, ignored; no data lost, no double write.
// - Async reset mid-SCROLL/CLEAR: abort immediately, return to reset values; buffer contents partially updated (allowed).
// STRUCTURE
// - Package text_pkg: COLS, ROWS, CELL_BASE, control code constants (CH_LF, CH_CR, CH_BS, CH_FF, CH_SPACE),
//   cell_t packed struct {pad[7:0], color[15:0], ch[7:0]}, state enum.
// - One sub-module: cell_addr_gen (row,col -> word address, plus linear scan counter) shared by PUT/SCROLL/CLEAR.
// TESTING (bench models text RAM with 1-cycle read latency)
// - Reset, idle: in_ready=1, cursor (0,0), no mem_we for 20 cycles.
// - Send 'A' color 16'hF800 -> one cycle mem_we, addr 1, wdata 32'h00F80041; cursor (1,0).
// - Send 80 printable chars -> addrs 1..80 written, cursor (0,1); then CR, BS at col 0 -> no writes, cursor (0,1).
// - Fill to row 26, send LF -> busy 2161 cycles; word 1 equals old word 81; words 2081..2160 = 32'h00FFFF20; cursor (0,26).
// - Send 8'h0C -> 2160 writes addrs 1..2160 blank, in_ready low throughout, cursor (0,0).
// - Assert rst 100 cycles into a scroll -> next cycle state IDLE, mem_we=0, in_ready=1, cursor (0,0).

Source files
------------

// File: rtl/text_pkg.sv
// Shared constants, cell layout and FSM state type for the text console writer.
package text_pkg;

    localparam int COLS       = 80;
    localparam int ROWS       = 27;
    localparam int CELL_BASE  = 1;
    localparam int NCELLS     = ROWS * COLS;
    localparam int COPY_CELLS = (ROWS - 1) * COLS;

    // During a scroll copy the bus carries the read address; a simultaneous
    // write lands SCROLL_SKEW words below it (cell k written while cell COLS+k+1 is read).
    localparam int SCROLL_SKEW = COLS + 1;

    localparam logic [15:0] FILL_COLOR = 16'hFFFF;

    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_BS    = 8'h08;
    localparam logic [7:0] CH_FF    = 8'h0C;
    localparam logic [7:0] CH_SPACE = 8'h20;

    typedef struct packed {
        logic [7:0]  pad;
        logic [15:0] color;
        logic [7:0]  ch;
    } cell_t;

    typedef enum logic [1:0] {
        IDLE,
        PUT,
        SCROLL,
        CLEAR
    } state_t;

    localparam cell_t BLANK_CELL = {8'h00, FILL_COLOR, CH_SPACE};

endpackage

// File: rtl/text_console_writer_if.sv
// Character stream in, text RAM bus out. When mem_we and mem_re are both high,
// mem_addr is the read address and the write goes to mem_addr - SCROLL_SKEW.
interface text_console_writer_if;

    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_char;
    logic [15:0] in_color;
    logic        mem_we;
    logic        mem_re;
    logic [11:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport slave (
        input  in_valid, in_char, in_color, mem_rdata,
        output in_ready, mem_we, mem_re, mem_addr, mem_wdata
    );

    modport master (
        output in_valid, in_char, in_color, mem_rdata,
        input  in_ready, mem_we, mem_re, mem_addr, mem_wdata
    );

endinterface

// File: rtl/text_console_writer_cell_addr_gen.sv
// Cursor-to-word-address mapping plus the linear scan counter used by scroll and clear.
module cell_addr_gen
    import text_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  row_i,
    input  logic [6:0]  col_i,
    input  logic        scan_clr_i,
    input  logic        scan_inc_i,
    output logic [11:0] cell_addr_o,
    output logic [11:0] scan_o
);

    logic [11:0] scan_q, scan_d;

    always_comb begin
        scan_d = scan_q;
        if (scan_clr_i) begin
            scan_d = '0;
        end else if (scan_inc_i) begin
            scan_d = scan_q + 12'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_q <= '0;
        end else begin
            scan_q <= scan_d;
        end
    end

    assign cell_addr_o = 12'(CELL_BASE) + 12'(row_i) * 12'(COLS) + {5'd0, col_i};
    assign scan_o      = scan_q;

endmodule

// File: rtl/text_console_writer.sv
// Accepts characters/control codes, writes cells into the text RAM, and
// handles cursor movement, scrolling and form-feed clearing.
module text_console_writer
    import text_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    text_console_writer_if.slave  bus,
    output logic [6:0]            cursor_col_o,
    output logic [4:0]            cursor_row_o,
    output logic                  busy_o
);

    state_t      state_q, state_d;
    logic [6:0]  col_q, col_d;
    logic [4:0]  row_q, row_d;
    logic        pend_q, pend_d;
    logic        ready_q, ready_d;
    logic        busy_q, busy_d;
    logic        we_q, we_d;
    logic        re_q, re_d;
    logic        pass_q, pass_d;
    logic [11:0] addr_q, addr_d;
    cell_t       wdata_q, wdata_d;

    logic        scan_clr, scan_inc;
    logic        scroll_out, clear_out;
    logic [11:0] cell_addr, scan, idx;

    cell_addr_gen u_addr (
        .clk         (clk),
        .rst         (rst),
        .row_i       (row_q),
        .col_i       (col_q),
        .scan_clr_i  (scan_clr),
        .scan_inc_i  (scan_inc),
        .cell_addr_o (cell_addr),
        .scan_o      (scan)
    );

    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        row_d      = row_q;
        pend_d     = pend_q;
        we_d       = 1'b0;
        re_d       = 1'b0;
        pass_d     = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        scan_clr   = 1'b0;
        scan_inc   = 1'b0;
        scroll_out = 1'b0;
        clear_out  = 1'b0;
        idx        = scan + 12'd1;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    case (bus.in_char)
                        CH_LF: begin
                            col_d = '0;
                            if (row_q == 5'(ROWS - 1)) begin
                                state_d    = SCROLL;
                                scan_clr   = 1'b1;
                                scroll_out = 1'b1;
                                idx        = '0;
                            end else begin
                                row_d = row_q + 5'd1;
                            end
                        end
                        CH_CR: col_d = '0;
                        CH_BS: begin
                            if (col_q != '0) begin
                                col_d   = col_q - 7'd1;
                                state_d = PUT;
                                we_d    = 1'b1;
                                addr_d  = cell_addr - 12'd1;
                                wdata_d = BLANK_CELL;
                            end
                        end
                        CH_FF: begin
                            col_d     = '0;
                            row_d     = '0;
                            state_d   = CLEAR;
                            scan_clr  = 1'b1;
                            clear_out = 1'b1;
                            idx       = '0;
                        end
                        default: begin
                            state_d = PUT;
                            we_d    = 1'b1;
                            addr_d  = cell_addr;
                            wdata_d = {8'h00, bus.in_color, bus.in_char};
                            if (col_q == 7'(COLS - 1)) begin
                                col_d = '0;
                                // Wrap off the last row: write first, scroll afterwards.
                                if (row_q == 5'(ROWS - 1)) begin
                                    pend_d = 1'b1;
                                end else begin
                                    row_d = row_q + 5'd1;
                                end
                            end else begin
                                col_d = col_q + 7'd1;
                            end
                        end
                    endcase
                end
            end
            PUT: begin
                if (pend_q) begin
                    pend_d     = 1'b0;
                    state_d    = SCROLL;
                    scan_clr   = 1'b1;
                    scroll_out = 1'b1;
                    idx        = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            SCROLL: begin
                if (scan == 12'(NCELLS)) begin
                    state_d = IDLE;
                end else begin
                    scan_inc   = 1'b1;
                    scroll_out = 1'b1;
                end
            end
            CLEAR: begin
                if (scan == 12'(NCELLS - 1)) begin
                    state_d = IDLE;
                end else begin
                    scan_inc  = 1'b1;
                    clear_out = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Scroll step idx: read cell COLS+idx, write cell idx-1 (copied data, then blanks).
        if (scroll_out) begin
            re_d    = (idx < 12'(COPY_CELLS));
            we_d    = (idx != 12'd0);
            pass_d  = (idx != 12'd0) && (idx <= 12'(COPY_CELLS));
            addr_d  = re_d ? 12'(CELL_BASE + COLS) + idx : 12'(CELL_BASE) + idx - 12'd1;
            wdata_d = BLANK_CELL;
        end
        if (clear_out) begin
            we_d    = 1'b1;
            addr_d  = 12'(CELL_BASE) + idx;
            wdata_d = BLANK_CELL;
        end

        ready_d = (state_d == IDLE);
        busy_d  = (state_d == SCROLL) || (state_d == CLEAR);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            col_q   <= '0;
            row_q   <= '0;
            pend_q  <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            we_q    <= 1'b0;
            re_q    <= 1'b0;
            pass_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            pend_q  <= pend_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            we_q    <= we_d;
            re_q    <= re_d;
            pass_q  <= pass_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    // Copy data arrives one cycle after its read, so it is forwarded straight to the write port.
    assign bus.mem_wdata = pass_q ? bus.mem_rdata : wdata_q;
    assign bus.in_ready  = ready_q;
    assign bus.mem_we    = we_q;
    assign bus.mem_re    = re_q;
    assign bus.mem_addr  = addr_q;
    assign cursor_col_o  = col_q;
    assign cursor_row_o  = row_q;
    assign busy_o        = busy_q;

endmodule

// File: tb/tb_text_console_writer.sv
// Directed bench: text RAM model with 1-cycle read latency, screen-grid reference
// model, per-cycle cursor/address checks and per-transaction cell/cycle-count checks.
module tb_text_console_writer;

    localparam logic [31:0] BLANK = 32'h00FFFF20;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    text_console_writer_if bus ();
    logic [6:0] cursor_col;
    logic [4:0] cursor_row;
    logic       busy;

    text_console_writer dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .cursor_col_o (cursor_col),
        .cursor_row_o (cursor_row),
        .busy_o       (busy)
    );

    function automatic logic [31:0] pat(int i);
        return 32'hA500_0000 | 32'(i);
    endfunction

    // Text RAM model plus activity counters
    logic [31:0] ram [0:4095];
    logic        ram_init_q = 1'b0;
    int          cnt_we = 0;
    int          cnt_busy = 0;
    int          cnt_low = 0;
    logic [11:0] last_waddr = '0;
    logic [31:0] last_wdata = '0;
    logic [11:0] waddr_now;
    assign waddr_now = bus.mem_re ? bus.mem_addr - 12'd81 : bus.mem_addr;

    always @(posedge clk) begin
        if (!ram_init_q) begin
            for (int i = 0; i < 4096; i++) ram[i] <= pat(i);
            ram_init_q <= 1'b1;
        end else if (!rst) begin
            if (bus.mem_we) begin
                ram[waddr_now] <= bus.mem_wdata;
                last_waddr     <= waddr_now;
                last_wdata     <= bus.mem_wdata;
                cnt_we         <= cnt_we + 1;
            end
            if (bus.mem_re) bus.mem_rdata <= ram[bus.mem_addr];
            cnt_busy <= cnt_busy + (busy ? 1 : 0);
            cnt_low  <= cnt_low + (bus.in_ready ? 0 : 1);
        end
    end

    // Reference model: screen grid and cursor
    logic [31:0] scr [0:2159];
    int m_row, m_col;
    int exp_wr, exp_busy, exp_low;
    int total = 0;
    int bad = 0;

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic m_newline();
        if (m_row == 26) begin
            for (int n = 0; n < 2080; n++) scr[n] = scr[n + 80];
            for (int n = 2080; n < 2160; n++) scr[n] = BLANK;
            exp_wr   += 2160;
            exp_busy += 2161;
            exp_low  += 2161;
        end else begin
            m_row++;
        end
    endtask

    task automatic model_byte(logic [7:0] ch, logic [15:0] color);
        exp_wr = 0; exp_busy = 0; exp_low = 0;
        case (ch)
            8'h0A: begin m_col = 0; m_newline(); end
            8'h0D: m_col = 0;
            8'h08: begin
                if (m_col > 0) begin
                    m_col--;
                    scr[m_row * 80 + m_col] = BLANK;
                    exp_wr = 1; exp_low = 1;
                end
            end
            8'h0C: begin
                for (int n = 0; n < 2160; n++) scr[n] = BLANK;
                m_row = 0; m_col = 0;
                exp_wr = 2160; exp_busy = 2160; exp_low = 2160;
            end
            default: begin
                scr[m_row * 80 + m_col] = {8'h00, color, ch};
                exp_wr = 1; exp_low = 1;
                m_col++;
                if (m_col == 80) begin m_col = 0; m_newline(); end
            end
        endcase
    endtask

    task automatic cmp_screen();
        int nbad = 0;
        for (int n = 0; n < 2160; n++) if (ram[n + 1] !== scr[n]) nbad++;
        chk("screen_bad_cells", 32'(nbad), 32'd0);
    endtask

    task automatic send(logic [7:0] ch, logic [15:0] color, bit wait_done);
        int w0, b0, l0, guard;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_char  = ch;
        bus.in_color = color;
        guard = 0;
        while (!bus.in_ready && guard < 5000) begin @(negedge clk); guard++; end
        if (!bus.in_ready) begin
            chk("accept_timeout", 32'(bus.in_ready), 32'd1);
            bus.in_valid = 1'b0;
            return;
        end
        w0 = cnt_we; b0 = cnt_busy; l0 = cnt_low;
        @(posedge clk);
        model_byte(ch, color);
        @(negedge clk);
        bus.in_valid = 1'b0;
        if (!wait_done) return;
        guard = 0;
        while (!bus.in_ready && guard < 5000) begin @(negedge clk); guard++; end
        chk("done_timeout", 32'(bus.in_ready), 32'd1);
        chk("txn_writes", 32'(cnt_we - w0), 32'(exp_wr));
        chk("txn_busy_cycles", 32'(cnt_busy - b0), 32'(exp_busy));
        chk("txn_ready_low", 32'(cnt_low - l0), 32'(exp_low));
        cmp_screen();
        $display("txn ch=%02h col=%0d row=%0d writes=%0d busy=%0d", ch, cursor_col, cursor_row,
                 cnt_we - w0, cnt_busy - b0);
    endtask

    initial begin
        int w0, b0, l0;
        logic [7:0] c;
        bus.in_valid = 1'b0;
        bus.in_char  = '0;
        bus.in_color = '0;
        for (int n = 0; n < 2160; n++) scr[n] = pat(n + 1);
        m_row = 0; m_col = 0;

        fork
            forever begin
                @(negedge clk);
                if (!rst) begin
                    if (bus.in_ready) begin
                        chk("idle_cursor_col", 32'(cursor_col), 32'(m_col));
                        chk("idle_cursor_row", 32'(cursor_row), 32'(m_row));
                        chk("idle_not_busy", 32'(busy), 32'd0);
                    end
                    if (bus.mem_we)
                        chk("waddr_in_range", 32'(waddr_now >= 12'd1 && waddr_now <= 12'd2160), 32'd1);
                    if (bus.mem_re) chk("read_only_when_busy", 32'(busy), 32'd1);
                end
            end
            begin
                #3000000;
                $display("FAIL watchdog: simulation time limit reached");
                $fatal(1, "watchdog");
            end
        join_none

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
        chk("rst_mem_re", 32'(bus.mem_re), 32'd0);
        chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cursor", {cursor_row, cursor_col}, 32'd0);
        rst = 1'b0;
        w0 = cnt_we;
        repeat (20) @(negedge clk);
        chk("idle_no_writes", 32'(cnt_we - w0), 32'd0);

        // Single printable
        send(8'h41, 16'hF800, 1'b1);
        chk("A_addr", 32'(last_waddr), 32'd1);
        chk("A_wdata", last_wdata, 32'h00F80041);
        chk("A_col", 32'(cursor_col), 32'd1);
        chk("A_row", 32'(cursor_row), 32'd0);

        // A full row from column 0, alternate chars presented while the writer is busy
        send(8'h0D, 16'h0, 1'b1);
        for (int i = 0; i < 80; i++) begin
            c = 8'h21 + 8'(i);
            send(c, 16'h1000 + 16'(i), (i % 2) == 1);
        end
        chk("row0_first", ram[1], 32'h00100021);
        chk("row0_last", ram[80], 32'h00104F70);
        chk("row0_col", 32'(cursor_col), 32'd0);
        chk("row0_row", 32'(cursor_row), 32'd1);

        // CR and BS at column 0 touch nothing
        w0 = cnt_we;
        send(8'h0D, 16'h0, 1'b1);
        send(8'h08, 16'h0, 1'b1);
        chk("crbs_writes", 32'(cnt_we - w0), 32'd0);
        chk("crbs_cursor", {cursor_row, cursor_col}, {20'd0, 5'd1, 7'd0});

        // Backspace over a character
        send(8'h0A, 16'h0, 1'b1);
        send(8'h78, 16'h001F, 1'b1);
        send(8'h08, 16'h0, 1'b1);
        chk("bs_addr", 32'(last_waddr), 32'd161);
        chk("bs_cell", ram[161], BLANK);
        chk("bs_cursor", {cursor_row, cursor_col}, {20'd0, 5'd2, 7'd0});

        // LF from the last row scrolls
        for (int i = 0; i < 24; i++) send(8'h0A, 16'h0, 1'b1);
        chk("at_last_row", 32'(cursor_row), 32'd26);
        b0 = cnt_busy;
        send(8'h0A, 16'h0, 1'b1);
        chk("scroll_busy_cycles", 32'(cnt_busy - b0), 32'd2161);
        chk("scroll_word1", ram[1], 32'hA5000051);
        chk("scroll_word81", ram[81], BLANK);
        chk("scroll_word2081", ram[2081], BLANK);
        chk("scroll_word2160", ram[2160], BLANK);
        chk("scroll_cursor", {cursor_row, cursor_col}, {20'd0, 5'd26, 7'd0});

        // Wrapping off the last row scrolls after the write
        for (int i = 0; i < 80; i++) begin
            c = 8'h41 + 8'(i % 26);
            send(c, 16'h07E0, 1'b1);
        end
        chk("wrap_cursor", {cursor_row, cursor_col}, {20'd0, 5'd26, 7'd0});

        // Form feed
        w0 = cnt_we; l0 = cnt_low;
        send(8'h0C, 16'h0, 1'b1);
        chk("ff_writes", 32'(cnt_we - w0), 32'd2160);
        chk("ff_ready_low", 32'(cnt_low - l0), 32'd2160);
        chk("ff_word1", ram[1], BLANK);
        chk("ff_word2160", ram[2160], BLANK);
        chk("ff_cursor", {cursor_row, cursor_col}, 32'd0);

        // Reset during a scroll
        for (int i = 0; i < 26; i++) send(8'h0A, 16'h0, 1'b1);
        send(8'h0A, 16'h0, 1'b0);
        repeat (99) @(negedge clk);
        chk("mid_scroll_busy", 32'(busy), 32'd1);
        #2;
        rst = 1'b1;
        m_row = 0; m_col = 0;
        #1;
        chk("abort_in_ready", 32'(bus.in_ready), 32'd1);
        chk("abort_mem_we", 32'(bus.mem_we), 32'd0);
        chk("abort_mem_re", 32'(bus.mem_re), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_cursor", {cursor_row, cursor_col}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        send(8'h0C, 16'h0, 1'b1);
        chk("word0_untouched", ram[0], 32'hA5000000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
